// File: rtl/draw_card_unit_pkg.sv
// Shared constants for the 21-game card source: card/count limits and 7-seg glyphs.
package draw_card_unit_pkg;

  localparam int unsigned CARD_W = 4;
  localparam int unsigned NUM_W  = 6;
  localparam int unsigned SEG_W  = 7;

  localparam logic [CARD_W-1:0] MAX_CARD  = 4'd13;
  localparam logic [CARD_W-1:0] MAX_COUNT = 4'd15;

  // Active-low glyphs, bit 6 = g .. bit 0 = a
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/draw_card_unit_hex.sv
// Seven-segment decoders: single hex nibble, and 0..63 as two decimal digits.
module hex_display
  import draw_card_unit_pkg::*;
(
  input  logic [CARD_W-1:0] in,
  output logic [SEG_W-1:0]  out
);

  // Nibble to active-low glyph, full 0..F set
  always_comb begin
    out = SEG_0;
    case (in)
      4'h0: out = SEG_0;
      4'h1: out = SEG_1;
      4'h2: out = SEG_2;
      4'h3: out = SEG_3;
      4'h4: out = SEG_4;
      4'h5: out = SEG_5;
      4'h6: out = SEG_6;
      4'h7: out = SEG_7;
      4'h8: out = SEG_8;
      4'h9: out = SEG_9;
      4'hA: out = SEG_A;
      4'hB: out = SEG_B;
      4'hC: out = SEG_C;
      4'hD: out = SEG_D;
      4'hE: out = SEG_E;
      4'hF: out = SEG_F;
      default: out = SEG_0;
    endcase
  end

endmodule

module hex_display_card
  import draw_card_unit_pkg::*;
(
  input  logic [NUM_W-1:0] in,
  output logic [SEG_W-1:0] tens,
  output logic [SEG_W-1:0] ones
);

  logic [NUM_W-1:0]  rem;
  logic [CARD_W-1:0] tens_val;
  logic [CARD_W-1:0] ones_val;

  // Binary to tens/ones by compare-subtract of 40, 20, 10 (input never exceeds 63)
  always_comb begin
    rem      = in;
    tens_val = '0;
    if (rem >= 6'd40) begin
      rem      = rem - 6'd40;
      tens_val = tens_val + 4'd4;
    end
    if (rem >= 6'd20) begin
      rem      = rem - 6'd20;
      tens_val = tens_val + 4'd2;
    end
    if (rem >= 6'd10) begin
      rem      = rem - 6'd10;
      tens_val = tens_val + 4'd1;
    end
    ones_val = CARD_W'(rem);
  end

  hex_display u_tens (.in(tens_val), .out(tens));
  hex_display u_ones (.in(ones_val), .out(ones));

endmodule

// File: rtl/draw_card_unit.sv
// Card source for the 21 game: draw_card generator/counter plus its 7-seg decoders.
module draw_card
  import draw_card_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
  input  logic              turn,
  output logic [CARD_W-1:0] card,
  output logic [CARD_W-1:0] seed
);

  logic in_prev;
  logic rise;

  assign rise = in & ~in_prev;

  // Edge detect, free-running seed 1..MAX_CARD, and card capture / saturating count
  always_ff @(posedge clock) begin
    if (reset) begin
      in_prev <= 1'b0;
      seed    <= 4'd1;
      card    <= '0;
    end else begin
      in_prev <= in;
      seed    <= (seed == MAX_CARD) ? 4'd1 : seed + 4'd1;
      if (rise) begin
        if (turn) card <= (card == MAX_COUNT) ? card : card + 4'd1;
        else      card <= seed;
      end
    end
  end

endmodule

module draw_card_unit
  import draw_card_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
  input  logic              turn,
  output logic [CARD_W-1:0] card,
  output logic [CARD_W-1:0] seed,
  output logic [SEG_W-1:0]  card_tens_c,
  output logic [SEG_W-1:0]  card_ones_c,
  input  logic [CARD_W-1:0] hex_in,
  output logic [SEG_W-1:0]  hex_seg_c,
  input  logic [NUM_W-1:0]  num_in,
  output logic [SEG_W-1:0]  num_tens_c,
  output logic [SEG_W-1:0]  num_ones_c
);

  logic [NUM_W-1:0] card_wide;

  assign card_wide = NUM_W'(card);

  draw_card u_draw (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .turn  (turn),
    .card  (card),
    .seed  (seed)
  );

  hex_display_card u_card_hex (.in(card_wide), .tens(card_tens_c), .ones(card_ones_c));
  hex_display      u_hex      (.in(hex_in),    .out(hex_seg_c));
  hex_display_card u_num_hex  (.in(num_in),    .tens(num_tens_c), .ones(num_ones_c));

endmodule

// File: tb/tb_draw_card_unit.sv
// Self-checking bench for draw_card_unit against a behavioural model of the draw rules.
module tb_draw_card_unit;

  logic       clock = 1'b0;
  logic       reset, in, turn;
  logic [3:0] card, seed, hex_in;
  logic [5:0] num_in;
  logic [6:0] card_tens_c, card_ones_c, hex_seg_c, num_tens_c, num_ones_c;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int seed_m, card_m;
  bit prev_m;
  logic [6:0] glyph [16];

  draw_card_unit dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .turn        (turn),
    .card        (card),
    .seed        (seed),
    .card_tens_c (card_tens_c),
    .card_ones_c (card_ones_c),
    .hex_in      (hex_in),
    .hex_seg_c   (hex_seg_c),
    .num_in      (num_in),
    .num_tens_c  (num_tens_c),
    .num_ones_c  (num_ones_c)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare on the falling edge
  task automatic step();
    @(posedge clock);
    if (reset) begin
      seed_m = 1; card_m = 0; prev_m = 0;
    end else begin
      if (in && !prev_m) begin
        if (turn) card_m = (card_m < 15) ? card_m + 1 : 15;
        else      card_m = seed_m;
      end
      seed_m = (seed_m % 13) + 1;
      prev_m = in;
    end
    @(negedge clock);
    chk("card", 16'(card), 16'(card_m));
    chk("seed", 16'(seed), 16'(seed_m));
    chk("card_tens", 16'(card_tens_c), 16'(glyph[card_m / 10]));
    chk("card_ones", 16'(card_ones_c), 16'(glyph[card_m % 10]));
  endtask

  task automatic do_reset(input logic t);
    reset = 1'b1; in = 1'b0; turn = t;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse();
    in = 1'b1; step();
    in = 1'b0; step();
  endtask

  initial begin
    int budget;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    hex_in = '0; num_in = '0;
    seed_m = 1; card_m = 0; prev_m = 0;

    // Reset state and seed sequence 1..13 wrapping to 1
    do_reset(1'b0);
    chk("rst_card", 16'(card), 16'd0);
    chk("rst_seed", 16'(seed), 16'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("seed_seq", 16'(seed), 16'(((i + 1) % 13) + 1));
      chk("idle_card", 16'(card), 16'd0);
    end

    // Dealer: press when seed is 7, then hold high 50 cycles
    budget = 0;
    while (seed_m != 7 && budget < 20) begin step(); budget++; end
    chk("seed7_reached", 16'(seed), 16'd7);
    in = 1'b1; step();
    chk("deal7", 16'(card), 16'd7);
    repeat (50) step();
    chk("hold7", 16'(card), 16'd7);
    in = 1'b0; step();

    // Counter: five presses, then saturation at 15
    do_reset(1'b1);
    repeat (5) pulse();
    chk("count5", 16'(card), 16'd5);
    repeat (15) pulse();
    chk("count_sat", 16'(card), 16'd15);

    // Reset coinciding with a rising edge wins
    reset = 1'b1; in = 1'b1; step();
    chk("rst_rise", 16'(card), 16'd0);
    reset = 1'b0; in = 1'b0; step();
    chk("rst_rise_after", 16'(card), 16'd0);
    pulse();
    chk("count_after_rst", 16'(card), 16'd1);

    // Randomized press patterns in both modes
    for (int r = 0; r < 4; r++) begin
      do_reset(1'(r % 2));
      for (int c = 0; c < 80; c++) begin
        in = ($urandom_range(0, 3) != 0) ? in : ~in;
        step();
      end
    end

    // Hex decoder sweep and spot checks
    for (int h = 0; h < 16; h++) begin
      hex_in = 4'(h); #1;
      chk("hex_sweep", 16'(hex_seg_c), 16'(glyph[h]));
    end
    hex_in = 4'hA; #1; chk("hex_A", 16'(hex_seg_c), 16'(7'b0001000));
    hex_in = 4'hD; #1; chk("hex_D", 16'(hex_seg_c), 16'(7'b0100001));

    // Decimal decoder: directed corners and random values
    num_in = 6'd21; #1;
    chk("dec21_tens", 16'(num_tens_c), 16'(7'b0100100));
    chk("dec21_ones", 16'(num_ones_c), 16'(7'b1111001));
    num_in = 6'd0; #1;
    chk("dec0_tens", 16'(num_tens_c), 16'(7'b1000000));
    chk("dec0_ones", 16'(num_ones_c), 16'(7'b1000000));
    num_in = 6'd63; #1;
    chk("dec63_tens", 16'(num_tens_c), 16'(7'b0000010));
    chk("dec63_ones", 16'(num_ones_c), 16'(7'b0110000));
    for (int k = 0; k < 64; k++) begin
      int v;
      v = (k < 32) ? int'($urandom_range(0, 63)) : k;
      num_in = 6'(v); #1;
      chk("dec_tens", 16'(num_tens_c), 16'(glyph[v / 10]));
      chk("dec_ones", 16'(num_ones_c), 16'(glyph[v % 10]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
